controlador_puntuacion: RTL and testbench
=========================================

# controlador_puntuacion

Score-sequencing controller for the drum-hit scoring path. It arbitrates hit reports from the drum pads round-robin and weights each hit by its judgement and the current combo multiplier. It keeps a saturating 13-bit running total and drives the score-total register through `puntuacionEntrada`/`enable`/`standBy`. It also runs the game-phase state machine (waiting, playing, paused, finished) that gates scoring.

## Interface
Parameters:
- `PUNTOS_OK`, 5, base points for judgement 01
- `PUNTOS_BIEN`, 10, base points for judgement 10
- `PUNTOS_PERFECTO`, 20, base points for judgement 11
- `PUNTOS_MAX`, 8191, saturation ceiling of the total (must fit 13 bits)
- `COMBO_PASO`, 8, consecutive hits per multiplier step (power of two)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — rising-edge clock
- `resetN` in 1 — asynchronous, active-low reset
- `iniciar` in 1 — start/restart request (level, sampled per edge)
- `pausa` in 1 — pause level
- `finCancion` in 1 — end-of-song pulse
- `solicitud` in 4 — per-pad hit request, held until granted
- `calificacion` in 8 — 2-bit judgement per pad; pad i at [2i+1:2i]; 00 miss, 01 ok, 10 good, 11 perfect
- `concedido` out 4 — one-hot grant, high one cycle
- `puntuacionEntrada` out 13 — running total presented to the score register
- `enable` out 1 — one-cycle load strobe for the score register
- `standBy` out 1 — high whenever not in JUGANDO
- `multiplicador` out 3 — current multiplier, 1..4
- `combo` out 8 — consecutive non-miss hits, saturates at 255
- `estado` out 2 — 00 ESPERA, 01 JUGANDO, 10 PAUSA, 11 FIN

## Operation
- States and transitions, evaluated per edge:
  - ESPERA: `iniciar` → JUGANDO.
  - JUGANDO: `finCancion` → FIN. Otherwise `pausa` → PAUSA.
  - PAUSA: `finCancion` → FIN. Otherwise `!pausa` → JUGANDO.
  - FIN: `iniciar` → ESPERA.
  - `finCancion` has priority over `pausa`.
- Entering JUGANDO from ESPERA:
  - total, `combo` and pointer are cleared; `multiplicador` is set to 1.
  - `puntuacionEntrada`=0 with one `enable` pulse, to clear the downstream register.
- Requests outside JUGANDO are ignored. No grant is issued and pads keep waiting.
- Arbitration (JUGANDO only): at most one grant per edge.
  - Search starts at pad (pointer+1) mod 4; the pointer becomes the granted pad.
  - Reset pointer is 3, so pad 0 wins first.
  - A pad granted at edge k is masked at edge k+1, so a pad that holds its request one extra cycle is not double-counted.
- Scoring of the granted pad:
  - Miss: 0 points; `combo`←0; `multiplicador`←1. Still strobes `enable` with the unchanged total.
  - Hit: points = base × pre-hit `multiplicador` (max 80, 7 bits). The sum is formed in 14 bits, then total = min(sum, `PUNTOS_MAX`).
  - After a hit: `combo`←min(combo+1, 255); `multiplicador`←min(1 + combo_new/`COMBO_PASO`, 4).
- PAUSA and FIN hold total, `combo` and `multiplicador`.

## Timing
- Reset values:
  - `estado`=ESPERA, `standBy`=1.
  - `concedido`=0, `enable`=0, `puntuacionEntrada`=0.
  - `combo`=0, `multiplicador`=1, pointer=3.
- Latency: a request sampled at edge k produces, during cycle k→k+1:
  - `concedido` one-hot,
  - updated `puntuacionEntrada`,
  - `enable`=1 and updated `combo`/`multiplicador`.
- Each output is a registered single-cycle pulse. No combinational input→output path.
- A pause or end at the same edge as a pending request: the state change wins and no grant is issued.
- `resetN` low mid-operation clears everything immediately, including a grant in flight.
- Total saturation: once at 8191, further hits keep 8191 and still pulse `enable`.

## Configuration
- `CONTROL_PUNTUACION_COMBO_EN` defined: combo multiplier active as described.
- Undefined:
  - `multiplicador` fixed at 1 and points = base.
  - `combo` still counts and still resets on a miss.

## Test plan
- Reset, then `iniciar`=1 one cycle → `estado`=01, `standBy`=0, one `enable` pulse with `puntuacionEntrada`=0.
- Pad 2 requests perfect ×1 → `concedido`=0100 for one cycle, total 20, `combo`=1, `enable` one cycle.
- All four pads request ok simultaneously, held → grants 0001, 0010, 0100, 1000 on consecutive edges, total 20, no pad granted twice.
- 8 consecutive ok hits, then 1 perfect → total 40+40=80, `multiplicador`=2 after hit 8; a following miss → `combo`=0, `multiplicador`=1, total unchanged.
- Preload near ceiling (hits to 8180), then perfect ×4 multiplier → total 8191; another hit → 8191, `enable` pulses.
- `pausa`=1 with pad 1 requesting → `estado`=10, no grant; `pausa`=0 → grant on the following edge. `finCancion` during PAUSA → `estado`=11; `iniciar` → ESPERA.

Source files
------------

// File: rtl/controlador_puntuacion.sv
// Score-sequencing controller: round-robin pad arbitration, judgement/combo weighting,
// saturating running total and game-phase FSM. Combo multiplier enabled by CONTROL_PUNTUACION_COMBO_EN.
module controlador_puntuacion #(
    parameter int unsigned PUNTOS_OK       = 5,
    parameter int unsigned PUNTOS_BIEN     = 10,
    parameter int unsigned PUNTOS_PERFECTO = 20,
    parameter int unsigned PUNTOS_MAX      = 8191,
    parameter int unsigned COMBO_PASO      = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        iniciar,
    input  logic        pausa,
    input  logic        finCancion,
    input  logic [3:0]  solicitud,
    input  logic [7:0]  calificacion,
    output logic [3:0]  concedido,
    output logic [12:0] puntuacionEntrada,
    output logic        enable,
    output logic        standBy,
    output logic [2:0]  multiplicador,
    output logic [7:0]  combo,
    output logic [1:0]  estado
);

    localparam int unsigned NUM_PADS  = 4;
    localparam int unsigned TOTAL_W   = 13;
    localparam int unsigned SUMA_W    = TOTAL_W + 1;
    localparam int unsigned PUNTOS_W  = 7;
    localparam int unsigned COMBO_MAX = 255;
    localparam int unsigned MULT_MAX  = 4;

    // Reject configurations the datapath widths cannot represent
    if (PUNTOS_MAX > 8191 || COMBO_PASO == 0 || (COMBO_PASO & (COMBO_PASO - 1)) != 0) begin : gParamCheck
        $error("controlador_puntuacion: invalid PUNTOS_MAX or COMBO_PASO");
    end

    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        JUGANDO = 2'b01,
        PAUSA   = 2'b10,
        FIN     = 2'b11
    } estado_t;

    estado_t              estadoActual, estadoSiguiente;
    logic [1:0]           puntero, punteroSig;
    logic [3:0]           concedidoSig;
    logic [TOTAL_W-1:0]   totalSig;
    logic                 enableSig;
    logic [2:0]           multSig;
    logic [7:0]           comboSig;
    logic [3:0]           pendientes;
    logic [1:0]           candidato;
    logic [1:0]           padSel;
    logic                 hayConcesion;
    logic [1:0]           juicio;
    logic [PUNTOS_W-1:0]  puntosBase;
    logic [PUNTOS_W-1:0]  puntos;
    logic [SUMA_W-1:0]    suma;
`ifdef CONTROL_PUNTUACION_COMBO_EN
    logic [7:0]           escalon;
`endif

    // A pad granted last edge is masked so a held request is not counted twice
    assign pendientes = solicitud & ~concedido;
    assign estado     = estadoActual;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) estadoActual <= ESPERA;
        else         estadoActual <= estadoSiguiente;
    end

    // Phase transitions; end-of-song outranks pause
    always_comb begin
        estadoSiguiente = estadoActual;
        case (estadoActual)
            ESPERA:  if (iniciar) estadoSiguiente = JUGANDO;
            JUGANDO: if (finCancion) estadoSiguiente = FIN;
                     else if (pausa) estadoSiguiente = PAUSA;
            PAUSA:   if (finCancion) estadoSiguiente = FIN;
                     else if (!pausa) estadoSiguiente = JUGANDO;
            FIN:     if (iniciar) estadoSiguiente = ESPERA;
            default: estadoSiguiente = ESPERA;
        endcase
    end

    // Arbitration and scoring; grants only while staying in JUGANDO
    always_comb begin
        concedidoSig = '0;
        enableSig    = 1'b0;
        totalSig     = puntuacionEntrada;
        comboSig     = combo;
        multSig      = multiplicador;
        punteroSig   = puntero;
        hayConcesion = 1'b0;
        padSel       = '0;
        candidato    = '0;
        juicio       = '0;
        puntosBase   = '0;
        puntos       = '0;
        suma         = '0;
`ifdef CONTROL_PUNTUACION_COMBO_EN
        escalon      = '0;
`endif
        if (estadoActual == ESPERA && iniciar) begin
            totalSig   = '0;
            comboSig   = '0;
            multSig    = 3'd1;
            punteroSig = 2'd3;
            enableSig  = 1'b1;
        end else if (estadoActual == JUGANDO && !finCancion && !pausa) begin
            for (int unsigned i = 1; i <= NUM_PADS; i++) begin
                candidato = puntero + 2'(i);
                if (!hayConcesion && pendientes[candidato]) begin
                    hayConcesion = 1'b1;
                    padSel       = candidato;
                end
            end
            if (hayConcesion) begin
                concedidoSig = 4'(1) << padSel;
                punteroSig   = padSel;
                enableSig    = 1'b1;
                juicio       = calificacion[{padSel, 1'b0} +: 2];
                case (juicio)
                    2'b01:   puntosBase = PUNTOS_W'(PUNTOS_OK);
                    2'b10:   puntosBase = PUNTOS_W'(PUNTOS_BIEN);
                    2'b11:   puntosBase = PUNTOS_W'(PUNTOS_PERFECTO);
                    default: puntosBase = '0;
                endcase
                if (juicio == 2'b00) begin
                    comboSig = '0;
                    multSig  = 3'd1;
                end else begin
                    puntos   = PUNTOS_W'(10'(puntosBase) * 10'(multiplicador));
                    suma     = {1'b0, puntuacionEntrada} + SUMA_W'(puntos);
                    totalSig = (suma > SUMA_W'(PUNTOS_MAX)) ? TOTAL_W'(PUNTOS_MAX) : suma[TOTAL_W-1:0];
                    comboSig = (combo == 8'(COMBO_MAX)) ? combo : combo + 8'd1;
`ifdef CONTROL_PUNTUACION_COMBO_EN
                    escalon  = comboSig / 8'(COMBO_PASO);
                    multSig  = (escalon >= 8'(MULT_MAX - 1)) ? 3'(MULT_MAX) : 3'(escalon) + 3'd1;
`else
                    multSig  = 3'd1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            concedido         <= '0;
            puntuacionEntrada <= '0;
            enable            <= 1'b0;
            standBy           <= 1'b1;
            multiplicador     <= 3'd1;
            combo             <= '0;
            puntero           <= 2'd3;
        end else begin
            concedido         <= concedidoSig;
            puntuacionEntrada <= totalSig;
            enable            <= enableSig;
            standBy           <= (estadoSiguiente != JUGANDO);
            multiplicador     <= multSig;
            combo             <= comboSig;
            puntero           <= punteroSig;
        end
    end

endmodule

// File: tb/tb_controlador_puntuacion.sv
// Bench for controlador_puntuacion: directed scenarios plus random traffic against a
// behavioural score model; honours CONTROL_PUNTUACION_COMBO_EN like the design.
module tb_controlador_puntuacion;

    logic        clk = 1'b0;
    logic        resetN;
    logic        iniciar, pausa, finCancion;
    logic [3:0]  solicitud;
    logic [7:0]  calificacion;
    logic [3:0]  concedido;
    logic [12:0] puntuacionEntrada;
    logic        enable, standBy;
    logic [2:0]  multiplicador;
    logic [7:0]  combo;
    logic [1:0]  estado;

    int nTotal = 0;
    int nBad   = 0;

    // Reference model state: phase 0..3, total, combo, multiplier, last winner, last granted pad
    int mState, mTotal, mCombo, mMult, mPtr, mLast;
    int base[4] = '{0, 5, 10, 20};

    controlador_puntuacion dut (
        .clk(clk), .resetN(resetN), .iniciar(iniciar), .pausa(pausa), .finCancion(finCancion),
        .solicitud(solicitud), .calificacion(calificacion), .concedido(concedido),
        .puntuacionEntrada(puntuacionEntrada), .enable(enable), .standBy(standBy),
        .multiplicador(multiplicador), .combo(combo), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0; mTotal = 0; mCombo = 0; mMult = 1; mPtr = 3; mLast = -1;
    endtask

    // Advance one edge: predict from the applied inputs, then compare every output
    task automatic step();
        int g = -1;
        int nxt = mState;
        bit en = 0;
        int q, p;
        case (mState)
            0: if (iniciar) begin
                   nxt = 1; mTotal = 0; mCombo = 0; mMult = 1; mPtr = 3; en = 1;
               end
            1: if (finCancion) nxt = 3;
               else if (pausa) nxt = 2;
               else begin
                   for (int k = 1; k <= 4; k++) begin
                       p = (mPtr + k) % 4;
                       if (g < 0 && solicitud[p] && p != mLast) g = p;
                   end
               end
            2: if (finCancion) nxt = 3; else if (!pausa) nxt = 1;
            default: if (iniciar) nxt = 0;
        endcase
        if (g >= 0) begin
            en = 1;
            mPtr = g;
            q = int'(calificacion[2*g +: 2]);
            if (q == 0) begin
                mCombo = 0; mMult = 1;
            end else begin
                mTotal = mTotal + base[q] * mMult;
                if (mTotal > 8191) mTotal = 8191;
                if (mCombo < 255) mCombo = mCombo + 1;
`ifdef CONTROL_PUNTUACION_COMBO_EN
                mMult = 1 + mCombo / 8;
                if (mMult > 4) mMult = 4;
`endif
            end
        end
        mLast  = g;
        mState = nxt;
        @(posedge clk);
        #1;
        chk("estado", 32'(estado), 32'(mState));
        chk("standBy", 32'(standBy), 32'(mState != 1));
        chk("concedido", 32'(concedido), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("enable", 32'(enable), 32'(en));
        chk("total", 32'(puntuacionEntrada), 32'(mTotal));
        chk("combo", 32'(combo), 32'(mCombo));
        chk("mult", 32'(multiplicador), 32'(mMult));
    endtask

    task automatic drive(input bit ini, input bit pau, input bit fin,
                         input logic [3:0] sol, input logic [7:0] cal);
        iniciar = ini; pausa = pau; finCancion = fin; solicitud = sol; calificacion = cal;
        step();
    endtask

    // From any phase back to a freshly started JUGANDO
    task automatic restart();
        if (mState == 1 || mState == 2) drive(0, 0, 1, 4'h0, 8'h00);
        if (mState == 3) drive(1, 0, 0, 4'h0, 8'h00);
        drive(1, 0, 0, 4'h0, 8'h00);
        drive(0, 0, 0, 4'h0, 8'h00);
    endtask

    initial begin
        int sat;
        resetN = 1'b0; iniciar = 0; pausa = 0; finCancion = 0; solicitud = '0; calificacion = '0;
        modelReset();
        #12;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_standBy", 32'(standBy), 32'd1);
        chk("rst_concedido", 32'(concedido), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_total", 32'(puntuacionEntrada), 32'd0);
        chk("rst_mult", 32'(multiplicador), 32'd1);
        @(negedge clk);
        resetN = 1'b1;

        // Requests while waiting are ignored
        drive(0, 0, 0, 4'hF, 8'hFF);
        // Start: clear pulse
        drive(1, 0, 0, 4'h0, 8'h00);
        chk("start_enable", 32'(enable), 32'd1);
        drive(0, 0, 0, 4'h0, 8'h00);
        // Pad 2 perfect
        drive(0, 0, 0, 4'b0100, 8'b0011_0000);
        chk("pad2_grant", 32'(concedido), 32'b0100);
        chk("pad2_total", 32'(puntuacionEntrada), 32'd20);
        drive(0, 0, 0, 4'h0, 8'h00);

        // All four pads ok, held: round robin from pad 0
        restart();
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 4'hF, 8'h55);
        chk("rr_total", 32'(puntuacionEntrada), 32'd20);
        drive(0, 0, 0, 4'h0, 8'h00);

        // Eight ok hits, one perfect, one miss
        restart();
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 4'b0011, 8'h05);
        chk("ok8_total", 32'(puntuacionEntrada), 32'd40);
        drive(0, 0, 0, 4'b0001, 8'h03);
`ifdef CONTROL_PUNTUACION_COMBO_EN
        chk("perf_total", 32'(puntuacionEntrada), 32'd80);
`else
        chk("perf_total", 32'(puntuacionEntrada), 32'd60);
`endif
        drive(0, 0, 0, 4'b0010, 8'h00);
        chk("miss_combo", 32'(combo), 32'd0);
        drive(0, 0, 0, 4'h0, 8'h00);

        // Pause wins over a pending request; resume grants on the next edge
        drive(0, 1, 0, 4'b0010, 8'h08);
        drive(0, 1, 0, 4'b0010, 8'h08);
        drive(0, 0, 0, 4'b0010, 8'h08);
        drive(0, 0, 0, 4'b0010, 8'h08);
        drive(0, 0, 0, 4'h0, 8'h00);
        drive(0, 1, 0, 4'h0, 8'h00);
        drive(0, 1, 1, 4'h0, 8'h00);
        chk("fin_estado", 32'(estado), 32'd3);
        drive(1, 0, 0, 4'h0, 8'h00);
        chk("back_espera", 32'(estado), 32'd0);

        // Saturation at the ceiling
        drive(1, 0, 0, 4'h0, 8'h00);
        sat = 0;
        for (int n = 0; n < 700 && sat < 4; n++) begin
            drive(0, 0, 0, 4'hF, 8'hFF);
            if (mTotal == 8191) sat++;
        end
        chk("sat_total", 32'(puntuacionEntrada), 32'd8191);
        chk("sat_enable", 32'(enable), 32'd1);

        // Asynchronous reset with a grant in flight
        drive(0, 0, 0, 4'hF, 8'hFF);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_concedido", 32'(concedido), 32'd0);
        chk("async_total", 32'(puntuacionEntrada), 32'd0);
        chk("async_estado", 32'(estado), 32'd0);
        chk("async_standBy", 32'(standBy), 32'd1);
        modelReset();
        @(negedge clk);
        resetN = 1'b1;
        drive(0, 0, 0, 4'h0, 8'h00);

        // Random traffic
        restart();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 12) == 0, ($urandom % 8) == 0, ($urandom % 60) == 0,
                  4'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
